// File: rtl/data_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_bridge
// Purpose  : Bridges the single-cycle datapath's data-memory port onto a
//            req/ack memory bus. One load or store becomes one bus
//            transaction. The core is stalled until that transaction
//            completes. Loaded words are returned on read_data.
// Revision : 1.0 - initial release
//
// Ports
//   clk              in   rising-edge clock
//   reset            in   asynchronous, active-low reset
//   mem_read         in   load strobe from control
//   mem_write        in   store strobe from control (wins over mem_read)
//   data_memory_addr in   access address from datapath
//   write_data       in   store data from datapath
//   read_data        out  registered load result, valid from DONE
//   stall            out  freezes PC / register-file writes (combinational)
//   align_fault      out  request rejected, address not word-aligned
//   bus_req          out  bus request, held until ack (registered)
//   bus_we           out  1 = write, 0 = read (registered)
//   bus_addr         out  latched address (registered)
//   bus_wdata        out  latched store data (registered)
//   bus_ack          in   bus completion, sampled on rising clk
//   bus_rdata        in   read data, valid with bus_ack
//   bus_err          out  timeout abort indicator, one DONE cycle
//
// Build option
//   DMEM_BRIDGE_TIMEOUT_EN : when defined, a REQ that sees no ack for
//   TIMEOUT_CYCLES cycles is aborted with bus_err. When undefined, REQ
//   waits indefinitely and bus_err is tied low.
// ============================================================================
module data_mem_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] data_memory_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              stall,
    output logic              align_fault,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              bus_err
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // The counter is 8 bits wide, so the limit must fit in 1..255.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range_bad
        $error("data_mem_bridge: TIMEOUT_CYCLES must be in 1..255");
    end

    logic [1:0]        state_q,     state_d;
    logic              bus_req_q,   bus_req_d;
    logic              bus_we_q,    bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q,  bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] read_data_q, read_data_d;

    logic w_req_present;
    logic w_aligned;
    logic w_accept;
    logic w_timeout;

    assign w_req_present = mem_read | mem_write;
    assign w_aligned     = (data_memory_addr[1:0] == 2'b00);
    assign w_accept      = (state_q == c_IDLE) && w_req_present && w_aligned;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       bus_err_q, bus_err_d;

    // cnt_q holds the number of ack-less REQ cycles already elapsed, so
    // the current cycle is the limit-th one when cnt_q equals limit-1.
    // An ack in that same cycle takes priority over the abort.
    assign w_timeout = (state_q == c_REQ) && !bus_ack && (cnt_q == c_TIMEOUT_LAST);

    always_comb begin
        cnt_d     = cnt_q;
        bus_err_d = 1'b0;
        if (w_accept) begin
            cnt_d = 8'd0;
        end else if ((state_q == c_REQ) && !bus_ack) begin
            cnt_d = cnt_q + 8'd1;
        end
        if (w_timeout) begin
            bus_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= 8'd0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign w_timeout = 1'b0;
    assign bus_err   = 1'b0;
`endif

    // State and registered-output flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= c_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            read_data_q <= read_data_d;
        end
    end

    // Next-state logic. DONE always returns to IDLE, so the strobe of the
    // retiring instruction is never sampled there and cannot re-issue.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (w_accept) begin
                    state_d = c_REQ;
                end
            end
            c_REQ: begin
                if (bus_ack || w_timeout) begin
                    state_d = c_DONE;
                end
            end
            c_DONE:  state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    // Output logic: combinational stall/fault plus the next values of the
    // registered bus outputs and read data.
    always_comb begin
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        read_data_d = read_data_q;

        // Qualified with reset so both stay low while reset is held,
        // whatever the strobes are doing.
        stall       = reset && (w_accept || (state_q == c_REQ));
        align_fault = reset && (state_q == c_IDLE) && w_req_present && !w_aligned;

        case (state_q)
            c_IDLE: begin
                if (w_accept) begin
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_write;
                    bus_addr_d  = data_memory_addr;
                    bus_wdata_d = write_data;
                end
            end
            c_REQ: begin
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        read_data_d = bus_rdata;
                    end
                end else if (w_timeout) begin
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        read_data_d = '0;
                    end
                end
            end
            default: begin
                bus_req_d = 1'b0;
            end
        endcase
    end

    assign read_data = read_data_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_bridge
// Purpose  : Directed bench for data_mem_bridge. The stimulus pushes the
//            expected completion of each access into a queue. A monitor
//            pops and checks that entry when it sees the stall fall.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] data_memory_addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        stall;
    logic        align_fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    always #5 clk = ~clk;

    data_mem_bridge #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .data_memory_addr (data_memory_addr),
        .write_data       (write_data),
        .read_data        (read_data),
        .stall            (stall),
        .align_fault      (align_fault),
        .bus_req          (bus_req),
        .bus_we           (bus_we),
        .bus_addr         (bus_addr),
        .bus_wdata        (bus_wdata),
        .bus_ack          (bus_ack),
        .bus_rdata        (bus_rdata),
        .bus_err          (bus_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          req_cycles;
    } exp_t;

    exp_t sb_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int pulses      = 0;
    int exp_pulses  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: samples on the falling edge, away from the active edge.
    // ------------------------------------------------------------------
    int   stall_cnt = 0;
    int   req_cnt   = 0;
    logic prev_stall = 1'b0;
    logic prev_req   = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            stall_cnt  = 0;
            req_cnt    = 0;
            prev_stall = 1'b0;
            prev_req   = 1'b0;
        end else begin
            if (bus_req && !prev_req) pulses++;
            if (bus_req) begin
                req_cnt++;
                if (sb_q.size() > 0) begin
                    chk("req_bus_addr",  bus_addr,  sb_q[0].addr);
                    chk("req_bus_we",    {31'd0, bus_we}, {31'd0, sb_q[0].we});
                    chk("req_bus_wdata", bus_wdata, sb_q[0].wdata);
                end
            end
            if (stall) stall_cnt++;
            if (prev_stall && !stall) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("done_stall_cycles", stall_cnt, e.req_cycles + 1);
                    chk("done_req_cycles",   req_cnt,   e.req_cycles);
                    chk("done_read_data",    read_data, e.rdata);
                    chk("done_bus_err",      {31'd0, bus_err}, {31'd0, e.err});
                    chk("done_bus_req",      {31'd0, bus_req}, 32'd0);
                end
                stall_cnt = 0;
                req_cnt   = 0;
            end
            prev_stall = stall;
            prev_req   = bus_req;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers. Called at 1 time unit after a rising edge.
    // The strobe stays asserted through DONE and is dropped afterwards.
    // ------------------------------------------------------------------
    task automatic access(input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int waits, input logic [31:0] rdata,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input int exp_req);
        exp_t e;
        int   n;
        int   guard;
        bit   done;
        e.addr = addr; e.we = wr; e.wdata = wd;
        e.rdata = exp_rd; e.err = exp_err; e.req_cycles = exp_req;
        sb_q.push_back(e);
        exp_pulses++;
        mem_read = rd; mem_write = wr; data_memory_addr = addr; write_data = wd;
        n = 0; guard = 0; done = 0;
        while (!done && guard < 100) begin
            @(posedge clk); #1;
            guard++;
            bus_ack = 1'b0;
            if (bus_req) begin
                if (n == waits) begin
                    bus_ack   = 1'b1;
                    bus_rdata = rdata;
                end
                n++;
            end else if (n > 0) begin
                done = 1;
            end
        end
        if (!done) chk("access_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
    endtask

    // Starts a read that never gets an ack, then resets mid-REQ.
    task automatic hang_then_reset(input logic [31:0] addr, input int cycles);
        exp_pulses++;
        bus_ack = 1'b0;
        mem_read = 1'b1; mem_write = 1'b0; data_memory_addr = addr;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk("hang_stall",   {31'd0, stall},   32'd1);
            chk("hang_bus_err", {31'd0, bus_err}, 32'd0);
            @(posedge clk); #1;
        end
        chk("hang_bus_req_before_reset", {31'd0, bus_req}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_bus_req_drop", {31'd0, bus_req}, 32'd0);
        chk("async_stall_drop",   {31'd0, stall},   32'd0);
        @(posedge clk); #1;
        mem_read = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_read_data", read_data, 32'd0);
        chk("post_reset_bus_req",   {31'd0, bus_req}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset held with hostile inputs: outputs must all stay low.
        reset = 1'b0; mem_read = 1'b1; mem_write = 1'b0;
        data_memory_addr = 32'd32; write_data = 32'd15;
        bus_ack = 1'b1; bus_rdata = 32'h77;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_read_data",   read_data, 32'd0);
        chk("rst_bus_req",     {31'd0, bus_req}, 32'd0);
        chk("rst_bus_we",      {31'd0, bus_we}, 32'd0);
        chk("rst_bus_addr",    bus_addr, 32'd0);
        chk("rst_bus_wdata",   bus_wdata, 32'd0);
        chk("rst_bus_err",     {31'd0, bus_err}, 32'd0);
        chk("rst_stall",       {31'd0, stall}, 32'd0);
        chk("rst_align_fault", {31'd0, align_fault}, 32'd0);
        @(posedge clk); #1;
        mem_read = 1'b0; bus_ack = 1'b0; bus_rdata = 32'd0;
        reset = 1'b1;
        @(posedge clk); #1;

        // Zero-wait load, then a store with 3 wait cycles.
        access(1'b1, 1'b0, 32'd32, 32'd0, 0, 32'd15, 32'd15, 1'b0, 1);
        access(1'b0, 1'b1, 32'd32, 32'd15, 3, 32'h0, 32'd15, 1'b0, 4);

        // Misaligned load is rejected without any bus activity.
        mem_read = 1'b1; data_memory_addr = 32'd34;
        @(negedge clk);
        chk("misalign_fault", {31'd0, align_fault}, 32'd1);
        chk("misalign_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        mem_read = 1'b0;
        @(negedge clk);
        chk("misalign_bus_req",   {31'd0, bus_req}, 32'd0);
        chk("misalign_read_data", read_data, 32'd15);
        chk("misalign_fault_clr", {31'd0, align_fault}, 32'd0);
        @(posedge clk); #1;

        // One-wait load; both strobes high (write wins, read_data kept).
        access(1'b1, 1'b0, 32'h100, 32'd0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2);
        access(1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, 0, 32'h12345678, 32'hDEADBEEF, 1'b0, 1);

        // Stray ack while idle is ignored.
        bus_ack = 1'b1; bus_rdata = 32'h5555;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_read_data", read_data, 32'hDEADBEEF);
        chk("stray_ack_bus_req",   {31'd0, bus_req}, 32'd0);
        @(posedge clk); #1;

        access(1'b1, 1'b0, 32'h104, 32'd0, 2, 32'h00000001, 32'h00000001, 1'b0, 3);

`ifdef DMEM_BRIDGE_TIMEOUT_EN
        // No ack: aborted after 4 REQ cycles with a one-cycle error.
        access(1'b1, 1'b0, 32'h200, 32'd0, 1000, 32'hFFFF, 32'd0, 1'b1, 4);
        @(negedge clk);
        chk("bus_err_one_cycle", {31'd0, bus_err}, 32'd0);
        @(posedge clk); #1;
        hang_then_reset(32'h300, 3);
`else
        // No ack: the stall persists indefinitely, no error is raised.
        hang_then_reset(32'h200, 12);
`endif

        access(1'b1, 1'b0, 32'h20, 32'd0, 0, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 1);

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        chk("bus_req_pulses",     pulses, exp_pulses);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
